dm_sized: RTL
=============

Name: dm_sized

Overview:
- Parametrised data memory for the single-cycle/pipelined CPU datapath, successor to the word-only data memory.
- Adds:
  - byte/half/word access with byte-lane writes
  - sign/zero extension on loads
  - registered (1-cycle) read with valid flag
  - valid/ready request handshake
  - sequential clear engine, replacing the array-wide reset loop
- Sits between the MEM stage and the memory bus; one request per cycle when ready.

Parameters:
- DEPTH, 1024, number of 32-bit words; power of two, 16..65536.
- ADDR_W, $clog2(DEPTH), word-index width; derived, do not override.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- clear  input  1  synchronous request to zero the whole array
- req_valid  input  1  access request present
- req_ready  output  1  request accepted this cycle when req_valid && req_ready
- we  input  1  1 = store, 0 = load
- width  input  2  00 word, 01 half, 10 byte, 11 reserved (treated as word)
- sign_ext  input  1  loads only: 1 sign-extend, 0 zero-extend
- addr  input  32  byte address
- wdata  input  32  store data; byte/half taken from low bits
- rdata  output  32  load result, extended
- rd_valid  output  1  rdata valid, one-cycle pulse
- busy  output  1  clear engine active
- addr_err  output  1  misaligned access flag, one-cycle pulse (see Optional Feature)

Behaviour:
- Reset (reset low, asynchronous):
  - state <= CLEAR, clear counter <= 0.
  - rdata <= 0, rd_valid <= 0, addr_err <= 0.
  - Array contents are undefined until CLEAR completes.
- FSM states IDLE and CLEAR:
  - CLEAR: each cycle writes 0 to word[cnt], cnt++.
  - After word DEPTH-1 is written, next state is IDLE. CLEAR therefore lasts exactly DEPTH cycles.
  - busy = (state==CLEAR).
- IDLE -> CLEAR on clear=1 at a clock edge. clear while already in CLEAR restarts cnt at 0.
- Reset mid-CLEAR restarts the clear from word 0.
- req_ready = (state==IDLE) && !clear. Clear wins over a simultaneous request; that request is not accepted and must be held.
- Word index = addr[ADDR_W+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH*4.
- Store on an accepted request, written at that edge:
  - word: all 4 lanes.
  - half: lanes {addr[1],0}+1..{addr[1],0}, data wdata[15:0].
  - byte: lane addr[1:0], data wdata[7:0].
  - Unselected lanes keep their value. rd_valid stays 0.
- Load on an accepted request:
  - rdata and rd_valid=1 are registered on the edge where the request is accepted, i.e. valid in the following cycle.
  - Field selected by addr[1:0]/width, then extended per sign_ext. Word ignores sign_ext.
  - rd_valid is a single-cycle pulse per load. Back-to-back loads give back-to-back pulses.
  - rdata holds its last value when rd_valid=0.
- Store followed by a load to the same word in the next accepted cycle returns the new data (write-then-read ordering, no stale value).
- No accesses are possible while busy. Loads and stores issued during busy simply wait on req_ready.

Optional Feature:
- Macro DM_ALIGN_CHECK_EN.
- Defined:
  - half with addr[0]=1, or word with addr[1:0]!=0, is misaligned.
  - The request is still accepted; addr_err pulses 1 the next cycle.
  - A misaligned store writes nothing. A misaligned load returns rdata=0 with rd_valid=1.
- Not defined:
  - addr_err is tied to 0.
  - Low address bits are forced aligned: half uses addr[1] only, word ignores addr[1:0].

Test Plan:
- Reset low 2 cycles, release -> busy=1 for exactly DEPTH cycles, req_ready=0 throughout, then word 0 and word DEPTH-1 both read 0x00000000.
- Store word 0x8765_4321 @0x10, then byte loads @0x10..0x13 with sign_ext=1 -> rdata 0x00000021, 0x00000043, 0xFFFFFF87... wait order: @0x13 gives 0xFFFFFF87, @0x12 0x00000065; half load @0x12 with sign_ext=0 -> 0x00008765; each rd_valid one cycle after accept.
- Store byte 0xAB @0x21 over word 0x11223344 @0x20 -> word read returns 0x1122AB44; store half 0xBEEF @0x22 -> 0xBEEFAB44.
- Wrap: with DEPTH=1024, store 0x5A5A5A5A @0x1000 -> load @0x0 returns 0x5A5A5A5A.
- clear and req_valid asserted in the same cycle (IDLE) -> req_ready=0, request not accepted, busy rises next cycle. Reset pulsed mid-clear -> clear restarts and busy lasts a full DEPTH cycles.
- DM_ALIGN_CHECK_EN: word store @0x06 -> addr_err pulse, memory unchanged. Half load @0x03 -> rdata=0, rd_valid=1, addr_err=1. Without the macro, a word store @0x06 writes word index 1.

Source files
------------

// File: rtl/dm_sized.sv
// dm_sized: byte/half/word data memory with registered loads, valid/ready
// handshake and a sequential clear engine. Define DM_ALIGN_CHECK_EN for misalignment trapping.
module dm_sized #(
    parameter int DEPTH = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        we,
    input  logic [1:0]  width,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        rd_valid,
    output logic        busy,
    output logic        addr_err
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    function automatic logic [3:0] lane_mask(input logic [1:0] w, input logic [1:0] a);
        case (w)
            2'b01:   lane_mask = a[1] ? 4'b1100 : 4'b0011;
            2'b10:   lane_mask = 4'b0001 << a;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

    // Replicate the narrow store value across lanes so the lane mask alone picks placement.
    function automatic logic [31:0] lane_data(input logic [1:0] w, input logic [31:0] d);
        case (w)
            2'b01:   lane_data = {2{d[15:0]}};
            2'b10:   lane_data = {4{d[7:0]}};
            default: lane_data = d;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] w,
                                                 input logic [1:0] a, input logic s);
        logic [31:0] sh;
        case (w)
            2'b01: begin
                sh = word >> {a[1], 4'b0000};
                load_extract = s ? {{16{sh[15]}}, sh[15:0]} : {16'h0000, sh[15:0]};
            end
            2'b10: begin
                sh = word >> {a, 3'b000};
                load_extract = s ? {{24{sh[7]}}, sh[7:0]} : {24'h000000, sh[7:0]};
            end
            default: begin
                sh = word;
                load_extract = sh;
            end
        endcase
    endfunction

`ifdef DM_ALIGN_CHECK_EN
    function automatic logic is_misaligned(input logic [1:0] w, input logic [1:0] a);
        case (w)
            2'b01:   is_misaligned = a[0];
            2'b10:   is_misaligned = 1'b0;
            default: is_misaligned = (a != 2'b00);
        endcase
    endfunction
`endif

    logic [31:0]       mem_r [DEPTH];
    logic [0:0]        state_r;
    logic [ADDR_W-1:0] cnt_r;
    logic [31:0]       rdata_r;
    logic              rd_valid_r;
    logic              addr_err_r;

    logic              req_ready_s;
    logic              accept_s;
    logic              wr_en_s;
    logic              misalign_s;
    logic [ADDR_W-1:0] idx_s;
    logic [3:0]        be_s;
    logic [31:0]       wd_s;

`ifdef DM_ALIGN_CHECK_EN
    assign misalign_s = is_misaligned(width, addr[1:0]);
`else
    assign misalign_s = 1'b0;
`endif

    // Request decode: handshake, word index (upper bits wrap) and lane selection.
    always_comb begin
        req_ready_s = (state_r == ST_IDLE) && !clear;
        accept_s    = req_valid && req_ready_s;
        wr_en_s     = accept_s && we && !misalign_s;
        idx_s       = addr[ADDR_W+1:2];
        be_s        = lane_mask(width, addr[1:0]);
        wd_s        = lane_data(width, wdata);
    end

    // Clear/idle state machine; a clear request (or reset) always restarts from word 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_CLEAR;
            cnt_r   <= '0;
        end else if (clear) begin
            state_r <= ST_CLEAR;
            cnt_r   <= '0;
        end else if (state_r == ST_CLEAR) begin
            if (cnt_r == LAST_IDX) begin
                state_r <= ST_IDLE;
                cnt_r   <= '0;
            end else begin
                cnt_r <= cnt_r + ADDR_W'(1);
            end
        end
    end

    // Storage array: clear engine zeroes one word per cycle, otherwise lane-masked stores.
    always_ff @(posedge clk) begin
        if (state_r == ST_CLEAR) begin
            mem_r[cnt_r] <= 32'h0000_0000;
        end else if (wr_en_s) begin
            for (int i = 0; i < 4; i++) begin
                if (be_s[i]) begin
                    mem_r[idx_s][i*8 +: 8] <= wd_s[i*8 +: 8];
                end
            end
        end
    end

    // Registered load path; rdata holds between loads, misaligned loads return zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_r    <= 32'h0000_0000;
            rd_valid_r <= 1'b0;
            addr_err_r <= 1'b0;
        end else begin
            rd_valid_r <= accept_s && !we;
            addr_err_r <= accept_s && misalign_s;
            if (accept_s && !we) begin
                rdata_r <= misalign_s ? 32'h0000_0000
                                      : load_extract(mem_r[idx_s], width, addr[1:0], sign_ext);
            end
        end
    end

    assign req_ready = req_ready_s;
    assign busy      = (state_r == ST_CLEAR);
    assign rdata     = rdata_r;
    assign rd_valid  = rd_valid_r;
    assign addr_err  = addr_err_r;
endmodule
